// File: rtl/sr_cmd_gen.sv
// rtl/sr_cmd_gen.sv - SR flop command stage: sync, debounce, edge detect, arbitrate, pace s/r pulses
//
// Optional feature macro: SR_CONFLICT_CNT_EN adds the saturating conflict_cnt output.
// Channel index 0 is the set path, index 1 is the clear path.
// A request edge is acted on in the same cycle it is detected (the pending
// flags are merged with fresh edges combinationally), which gives the
// DB_CYCLES+3 edge latency from a raw level to the registered pulse.

module sr_cmd_gen #(
  parameter int DB_CYCLES  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int PRIORITY   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_raw,
  input  logic       clr_raw,
  output logic       s,
  output logic       r,
  output logic       q_shadow,
`ifdef SR_CONFLICT_CNT_EN
  output logic       conflict,
  output logic [7:0] conflict_cnt
`else
  output logic       conflict
`endif
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t        state;
  logic [GW-1:0] gap_cnt;

  logic [1:0]    raw;
  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic [1:0]    stable;
  logic [1:0]    stable_d;
  logic [1:0]    rise;
  logic [CW-1:0] db_cnt [2];

  logic          pend_set;
  logic          pend_clr;
  logic          cand_set;
  logic          cand_clr;
  logic          collide;
  logic          want_set;
  logic          want_clr;
  logic          can_issue;

  assign raw  = {clr_raw, set_raw};
  assign rise = stable & ~stable_d;

  // Two-flop synchroniser on each raw level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 2'b00;
      sync_b <= 2'b00;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Debounce: accept a new level only after DB_CYCLES consecutive differing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable    <= 2'b00;
      stable_d  <= 2'b00;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      stable_d <= stable;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Merge fresh edges with pending flags; the newest request displaces its opposite,
  // and only a genuine collision goes through the priority rule.
  always_comb begin
    cand_set = rise[0] | (pend_set & ~rise[1]);
    cand_clr = rise[1] | (pend_clr & ~rise[0]);
    collide  = cand_set & cand_clr;
    want_set = cand_set;
    want_clr = cand_clr;
    if (collide) begin
      if (PRIORITY == 1) begin
        want_set = 1'b1;
        want_clr = 1'b0;
      end else if (PRIORITY == 2) begin
        want_set = 1'b0;
        want_clr = 1'b0;
      end else begin
        want_set = 1'b0;
        want_clr = 1'b1;
      end
    end
  end

  // A pulse may launch from IDLE or from the final GAP cycle, which keeps the spacing at exactly GAP_CYCLES idle cycles.
  assign can_issue = (state == ST_IDLE) || ((state == ST_GAP) && (gap_cnt == GAP_LAST));

  // Pulse FSM: IDLE -> ISSUE -> GAP -> IDLE with registered s/r/q_shadow/conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gap_cnt  <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      q_shadow <= 1'b0;
      conflict <= 1'b0;
      pend_set <= 1'b0;
      pend_clr <= 1'b0;
    end else begin
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= collide;
      pend_set <= want_set;
      pend_clr <= want_clr;
      if (can_issue && want_set) begin
        s        <= 1'b1;
        q_shadow <= 1'b1;
        pend_set <= 1'b0;
        state    <= ST_ISSUE;
      end else if (can_issue && want_clr) begin
        r        <= 1'b1;
        q_shadow <= 1'b0;
        pend_clr <= 1'b0;
        state    <= ST_ISSUE;
      end else begin
        case (state)
          ST_ISSUE: begin
            if (GAP_CYCLES > 0) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef SR_CONFLICT_CNT_EN
  // Saturating count of collisions, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= 8'd0;
    end else if (collide && (conflict_cnt != 8'hFF)) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb/tb_sr_cmd_gen.sv - directed table-driven bench for sr_cmd_gen

module tb_sr_cmd_gen;

  logic clk;
  logic rst_n;
  logic set_raw;
  logic clr_raw;
  logic s, r, q_shadow, conflict;
  logic s2, r2, q2, conflict2;
`ifdef SR_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
  logic [7:0] conflict_cnt2;
`endif

  int tests = 0;
  int fails = 0;

  sr_cmd_gen #(.DB_CYCLES(4), .GAP_CYCLES(2), .PRIORITY(0)) dut (
    .clk(clk), .rst_n(rst_n), .set_raw(set_raw), .clr_raw(clr_raw),
    .s(s), .r(r), .q_shadow(q_shadow),
`ifdef SR_CONFLICT_CNT_EN
    .conflict(conflict), .conflict_cnt(conflict_cnt)
`else
    .conflict(conflict)
`endif
  );

  sr_cmd_gen #(.DB_CYCLES(4), .GAP_CYCLES(2), .PRIORITY(2)) dut_p2 (
    .clk(clk), .rst_n(rst_n), .set_raw(set_raw), .clr_raw(clr_raw),
    .s(s2), .r(r2), .q_shadow(q2),
`ifdef SR_CONFLICT_CNT_EN
    .conflict(conflict2), .conflict_cnt(conflict_cnt2)
`else
    .conflict(conflict2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int s_on, s_off, c_on, c_off;
    int s_edge, s_num, r_edge, r_num, cf_edge;
    int p2_s_num, p2_r_num;
    int q_end;
  } vec_t;

  vec_t vecs [7];

  int s_edge, s_num, r_edge, r_num, cf_edge, cf_num, ovl;
  int p2_s, p2_r, p2_cf, q_at_s;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    set_raw = 1'b0;
    clr_raw = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_rec();
    s_edge = -1; s_num = 0; r_edge = -1; r_num = 0;
    cf_edge = -1; cf_num = 0; ovl = 0;
    p2_s = 0; p2_r = 0; p2_cf = -1; q_at_s = -1;
  endtask

  // Drive levels for edges 1..n and record what each edge produced.
  task automatic run(input int n, input int s_on, input int s_off, input int c_on, input int c_off);
    for (int k = 1; k <= n; k++) begin
      set_raw = (k >= s_on) && (k < s_off);
      clr_raw = (k >= c_on) && (k < c_off);
      @(posedge clk);
      #1;
      if (s) begin
        if (s_edge < 0) begin
          s_edge = k;
          q_at_s = int'(q_shadow);
        end
        s_num++;
      end
      if (r) begin
        if (r_edge < 0) r_edge = k;
        r_num++;
      end
      if (conflict) begin
        if (cf_edge < 0) cf_edge = k;
        cf_num++;
      end
      if (s && r) ovl++;
      if (s2) p2_s++;
      if (r2) p2_r++;
      if (conflict2 && p2_cf < 0) p2_cf = k;
    end
  endtask

  initial begin
    //        s_on s_off c_on c_off s_e s_n r_e r_n cf  p2s p2r q
    vecs[0] = '{1, 11,  0,  0,   7, 1, -1, 0, -1, 1, 0, 1};
    vecs[1] = '{1,  4,  0,  0,  -1, 0, -1, 0, -1, 0, 0, 0};
    vecs[2] = '{1, 15,  1, 15,  -1, 0,  7, 1,  7, 0, 0, 0};
    vecs[3] = '{1, 20,  2, 20,   7, 1, 10, 1, -1, 1, 1, 0};
    vecs[4] = '{0,  0,  1, 12,  -1, 0,  7, 1, -1, 0, 1, 0};
    vecs[5] = '{1, 12, 14, 26,   7, 1, 20, 1, -1, 1, 1, 0};
    vecs[6] = '{3, 20,  1, 20,  10, 1,  7, 1, -1, 1, 1, 1};

    rst_n   = 1'b0;
    set_raw = 1'b0;
    clr_raw = 1'b0;
    #1;
    chk("reset_outputs", int'({s, r, q_shadow, conflict}), 0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      clear_rec();
      run(30, vecs[i].s_on, vecs[i].s_off, vecs[i].c_on, vecs[i].c_off);
      $display("vector %0d", i);
      chk("s_edge",   s_edge,         vecs[i].s_edge);
      chk("s_num",    s_num,          vecs[i].s_num);
      chk("r_edge",   r_edge,         vecs[i].r_edge);
      chk("r_num",    r_num,          vecs[i].r_num);
      chk("cf_edge",  cf_edge,        vecs[i].cf_edge);
      chk("cf_num",   cf_num,         (vecs[i].cf_edge >= 0) ? 1 : 0);
      chk("s_r_ovl",  ovl,            0);
      chk("q_end",    int'(q_shadow), vecs[i].q_end);
      chk("p2_s_num", p2_s,           vecs[i].p2_s_num);
      chk("p2_r_num", p2_r,           vecs[i].p2_r_num);
      chk("p2_cf",    p2_cf,          vecs[i].cf_edge);
      if (vecs[i].s_edge >= 0) chk("q_at_s", q_at_s, 1);
    end

    // Asynchronous reset with set_raw held, then re-qualification after release.
    chk("h1_pre_q", int'(q_shadow), 1);
    @(negedge clk);
    set_raw = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("h1_async_rst", int'({s, r, q_shadow, conflict}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_rec();
    run(12, 1, 100, 0, 0);
    chk("h1_s_edge", s_edge, 7);
    chk("h1_s_num",  s_num,  1);
    chk("h1_q_at_s", q_at_s, 1);
    chk("h1_r_num",  r_num,  0);

    // Reset pulse during GAP while a clear is pending.
    do_reset();
    clear_rec();
    run(8, 1, 100, 2, 100);
    chk("h2_s_edge", s_edge, 7);
    chk("h2_r_before", r_num, 0);
    @(negedge clk);
    set_raw = 1'b0;
    clr_raw = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_rec();
    run(20, 0, 0, 0, 0);
    chk("h2_r_num", r_num, 0);
    chk("h2_s_num", s_num, 0);
    chk("h2_outputs", int'({s, r, q_shadow, conflict}), 0);

`ifdef SR_CONFLICT_CNT_EN
    // Saturation of the collision counter.
    do_reset();
    clear_rec();
    for (int j = 0; j < 300; j++) begin
      run(8, 1, 100, 1, 100);
      run(8, 0, 0, 0, 0);
      if (j == 9) chk("cnt_at_10", int'(conflict_cnt), 10);
    end
    chk("cf_pulses", cf_num, 300);
    chk("cnt_sat", int'(conflict_cnt), 255);
    chk("cnt_sat_p2", int'(conflict_cnt2), 255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
